// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS trace capture block.
// MIPS_TRACE_TSTAMP_EN adds a 32-bit timestamp field to each record.
package mips_trace_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DRAIN
  } trace_state_t;

  typedef struct packed {
`ifdef MIPS_TRACE_TSTAMP_EN
    logic [31:0]       tstamp;
`endif
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] res;
  } trace_rec_t;

endpackage

// File: rtl/mips_trace_ram.sv
// Trace record storage: flop array, one synchronous write port, one asynchronous read port.
module mips_trace_ram
  import mips_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = trace_rec_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  rec_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output rec_t                     rdata
);

  rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buf.sv
// Triggered circular trace capture with oldest-first valid/ready drain.
// MIPS_TRACE_TSTAMP_EN adds a free-running cycle stamp per record and the out_tstamp port.
module mips_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int POST_TRIG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              force_trig,
  input  logic              tr_valid,
  input  logic [DATA_W-1:0] tr_pc,
  input  logic [DATA_W-1:0] tr_instr,
  input  logic [DATA_W-1:0] tr_in1,
  input  logic [DATA_W-1:0] tr_in2,
  input  logic [DATA_W-1:0] tr_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [DATA_W-1:0] out_res,
`ifdef MIPS_TRACE_TSTAMP_EN
  output logic [31:0]       out_tstamp,
`endif
  output logic              out_last,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic              wrapped
);
  import mips_trace_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Same layout as trace_rec_t, sized by this instance's DATA_W.
  typedef struct packed {
`ifdef MIPS_TRACE_TSTAMP_EN
    logic [31:0]       tstamp;
`endif
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] res;
  } rec_t;

  trace_state_t  state, state_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n, post_cnt, post_n;
  logic          wrapped_n, trig_n, we, hit;
  rec_t          wrec, rrec;

  assign wrec.pc    = tr_pc;
  assign wrec.instr = tr_instr;
  assign wrec.in1   = tr_in1;
  assign wrec.in2   = tr_in2;
  assign wrec.res   = tr_res;

`ifdef MIPS_TRACE_TSTAMP_EN
  logic [31:0] tstamp;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tstamp <= '0;
    else      tstamp <= tstamp + 32'd1;
  end
  assign wrec.tstamp = tstamp;
  assign out_tstamp  = out_valid ? rrec.tstamp : '0;
`endif

  mips_trace_ram #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wrec),
    .raddr (rd_ptr),
    .rdata (rrec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      wrapped   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      post_cnt  <= post_n;
      wrapped   <= wrapped_n;
      triggered <= trig_n;
    end
  end

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    post_n    = post_cnt;
    wrapped_n = wrapped;
    trig_n    = triggered;
    we        = 1'b0;
    hit       = force_trig || (tr_valid && (tr_pc == trig_pc));
    unique case (state)
      IDLE: begin
        if (arm) begin
          state_n   = ARMED;
          wr_ptr_n  = '0;
          count_n   = '0;
          wrapped_n = 1'b0;
          trig_n    = 1'b0;
        end
      end
      ARMED, POST: begin
        if (tr_valid) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          if (count == FULL) wrapped_n = 1'b1;
          else               count_n   = count + 1'b1;
        end
        if (state == ARMED && hit) begin
          trig_n = 1'b1;
          if (POST_TRIG == 0) begin
            state_n = DRAIN;
          end else begin
            state_n = POST;
            post_n  = CW'(POST_TRIG);
          end
        end else if (state == POST && tr_valid) begin
          post_n = post_cnt - 1'b1;
          if (post_cnt == CW'(1)) state_n = DRAIN;
        end
        // Oldest record sits count entries behind the write pointer; FULL truncates to 0.
        rd_ptr_n = wr_ptr_n - count_n[PW-1:0];
      end
      DRAIN: begin
        if (arm) begin
          state_n   = ARMED;
          wr_ptr_n  = '0;
          rd_ptr_n  = '0;
          count_n   = '0;
          wrapped_n = 1'b0;
          trig_n    = 1'b0;
        end else if (count == '0) begin
          state_n = IDLE;
        end else if (out_ready) begin
          rd_ptr_n = rd_ptr + 1'b1;
          count_n  = count - 1'b1;
          if (count == CW'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_valid = (state == DRAIN) && (count != '0);
  assign out_last  = out_valid && (count == CW'(1));
  assign armed     = (state == ARMED) || (state == POST);
  assign done      = (state == DRAIN);
  assign out_pc    = out_valid ? rrec.pc    : '0;
  assign out_instr = out_valid ? rrec.instr : '0;
  assign out_in1   = out_valid ? rrec.in1   : '0;
  assign out_in2   = out_valid ? rrec.in2   : '0;
  assign out_res   = out_valid ? rrec.res   : '0;

endmodule
